// File: rtl/ssp_overlay_mixer.sv
// rtl/ssp_overlay_mixer.sv - overlay/Apple pixel mixer with keying, alpha fade and soft-switch registers
//
// Purpose: merges an OVL_W-bit overlay pixel stream onto the VID_W-bit Apple
// pixel stream through a two-stage pix_en_i-qualified pipeline. A small slot
// I/O register bank holds the display switches, key mode and fade settings.
// Optional feature macro: SSP_OVERLAY_FADE_EN (alpha blending + fade FSM).
//
// Ports:
//   clk_logic_i, reset_i           clock, synchronous active-high reset
//   wr_stb_i, rd_stb_i, addr_i,
//   data_i, data_o, rd_en_o        slot register bus
//   frame_start_i                  first-pixel-of-frame pulse (fade timing)
//   pix_en_i, apple_*_i, ovl_*_i,
//   ovl_transparent_i              pixel inputs
//   mix_*_o, mix_valid_o           mixed pixel output (2-clock latency)
//   overlay_on_o                   current overlay switch
module ssp_overlay_mixer #(
    parameter int   OVL_W         = 4,
    parameter int   VID_W         = 8,
    parameter logic FORCE_OVERLAY = 1'b0
) (
    input  logic             clk_logic_i,
    input  logic             reset_i,
    input  logic             wr_stb_i,
    input  logic             rd_stb_i,
    input  logic [3:0]       addr_i,
    input  logic [7:0]       data_i,
    output logic [7:0]       data_o,
    output logic             rd_en_o,
    input  logic             frame_start_i,
    input  logic             pix_en_i,
    input  logic [VID_W-1:0] apple_r_i,
    input  logic [VID_W-1:0] apple_g_i,
    input  logic [VID_W-1:0] apple_b_i,
    input  logic [OVL_W-1:0] ovl_r_i,
    input  logic [OVL_W-1:0] ovl_g_i,
    input  logic [OVL_W-1:0] ovl_b_i,
    input  logic             ovl_transparent_i,
    output logic [VID_W-1:0] mix_r_o,
    output logic [VID_W-1:0] mix_g_o,
    output logic [VID_W-1:0] mix_b_o,
    output logic             mix_valid_o,
    output logic             overlay_on_o
);
    localparam int BW = VID_W + 5;

    logic       apple_sw_q, apple_sw_d;
    logic       ovl_sw_q, ovl_sw_d;
    logic [1:0] key_mode_q, key_mode_d;
    logic [4:0] alpha_cur;
    logic [3:0] fade_rate;
    logic       fading;

    // Bit replication: the overlay MSBs repeat down into the low bits.
    function automatic logic [VID_W-1:0] expand(input logic [OVL_W-1:0] c);
        logic [VID_W-1:0] r;
        for (int i = 0; i < VID_W; i++) begin
            r[VID_W-1-i] = c[OVL_W-1-(i % OVL_W)];
        end
        return r;
    endfunction

    function automatic logic [VID_W-1:0] blend(input logic [VID_W-1:0] o,
                                               input logic [VID_W-1:0] b,
                                               input logic [4:0]       a);
`ifdef SSP_OVERLAY_FADE_EN
        logic [BW-1:0] acc;
        acc = BW'(o) * BW'(a) + BW'(b) * BW'(5'd16 - a);
        return acc[VID_W+3:4];
`else
        // alpha is only ever 0 or 16 here
        return a[4] ? o : b;
`endif
    endfunction

    // Switch and key-mode register writes
    always_comb begin
        apple_sw_d = apple_sw_q;
        ovl_sw_d   = ovl_sw_q;
        key_mode_d = key_mode_q;
        if (wr_stb_i) begin
            case (addr_i)
                4'h3: apple_sw_d = 1'b0;
                4'h4: apple_sw_d = 1'b1;
                4'h5: ovl_sw_d   = FORCE_OVERLAY;
                4'h6: ovl_sw_d   = 1'b1;
                4'h8: key_mode_d = data_i[1:0];
                default: ;
            endcase
        end
    end

`ifdef SSP_OVERLAY_FADE_EN
    typedef enum logic {IDLE, STEP} fade_state_t;
    fade_state_t state_q, state_d;
    logic [4:0]  alpha_tgt_q, alpha_tgt_d;
    logic [4:0]  alpha_cur_q, alpha_cur_d;
    logic [3:0]  fade_rate_q, fade_rate_d;
    logic [3:0]  frame_cnt_q, frame_cnt_d;
    logic        unused_data;

    assign unused_data = ^data_i[7:5];

    always_comb begin
        alpha_tgt_d = alpha_tgt_q;
        fade_rate_d = fade_rate_q;
        if (wr_stb_i && addr_i == 4'h9) begin
            alpha_tgt_d = (data_i[4:0] > 5'd16) ? 5'd16 : data_i[4:0];
        end
        if (wr_stb_i && addr_i == 4'hA) begin
            fade_rate_d = data_i[3:0];
        end
    end

    // Fade FSM compares against alpha_tgt_d so a same-cycle target write wins.
    always_comb begin
        state_d     = state_q;
        frame_cnt_d = frame_cnt_q;
        alpha_cur_d = alpha_cur_q;
        if (frame_start_i) begin
            case (state_q)
                IDLE: begin
                    if (alpha_cur_q != alpha_tgt_d) begin
                        frame_cnt_d = fade_rate_q;
                        state_d     = STEP;
                    end
                end
                STEP: begin
                    if (frame_cnt_q != 4'd0) begin
                        frame_cnt_d = frame_cnt_q - 4'd1;
                    end else if (fade_rate_q == 4'd0) begin
                        alpha_cur_d = alpha_tgt_d;
                    end else begin
                        if (alpha_cur_q < alpha_tgt_d) begin
                            alpha_cur_d = alpha_cur_q + 5'd1;
                        end else if (alpha_cur_q > alpha_tgt_d) begin
                            alpha_cur_d = alpha_cur_q - 5'd1;
                        end
                        frame_cnt_d = fade_rate_q;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
        if (state_q == STEP && alpha_cur_d == alpha_tgt_d) begin
            state_d = IDLE;
        end
    end

    always_ff @(posedge clk_logic_i) begin
        if (reset_i) begin
            state_q     <= IDLE;
            alpha_tgt_q <= 5'd16;
            alpha_cur_q <= 5'd16;
            fade_rate_q <= 4'd0;
            frame_cnt_q <= 4'd0;
        end else begin
            state_q     <= state_d;
            alpha_tgt_q <= alpha_tgt_d;
            alpha_cur_q <= alpha_cur_d;
            fade_rate_q <= fade_rate_d;
            frame_cnt_q <= frame_cnt_d;
        end
    end

    assign alpha_cur = alpha_cur_q;
    assign fade_rate = fade_rate_q;
    assign fading    = (state_q == STEP);
`else
    logic unused_data;

    assign unused_data = ^{data_i[7:2], frame_start_i};
    assign alpha_cur   = 5'd16;
    assign fade_rate   = 4'd0;
    assign fading      = 1'b0;
`endif

    // Register reads
    logic [7:0] rd_data;
    always_comb begin
        rd_data = 8'h00;
        rd_en_o = 1'b0;
        if (rd_stb_i) begin
            rd_en_o = 1'b1;
            case (addr_i)
                4'h8: rd_data = {6'b0, key_mode_q};
                4'h9: rd_data = {3'b0, alpha_cur};
                4'hA: rd_data = {4'b0, fade_rate};
                4'hB: rd_data = {fading, ovl_sw_q, apple_sw_q, key_mode_q, 3'b0};
                default: rd_en_o = 1'b0;
            endcase
        end
    end
    assign data_o       = rd_en_o ? rd_data : 8'h00;
    assign overlay_on_o = ovl_sw_q;

    // Stage 1: keying and base/overlay selection with current switches
    logic [2:0][VID_W-1:0] s1_base_q, s1_base_d, s1_ovl_q, s1_ovl_d;
    logic [4:0]            s1_alpha_q, s1_alpha_d;
    logic                  s1_valid_q, s1_valid_d;
    logic                  keyed;

    always_comb begin
        s1_base_d  = s1_base_q;
        s1_ovl_d   = s1_ovl_q;
        s1_alpha_d = s1_alpha_q;
        s1_valid_d = pix_en_i;
        case (key_mode_q)
            2'd0:    keyed = (|ovl_r_i) | (|ovl_g_i) | (|ovl_b_i);
            2'd1:    keyed = ~ovl_transparent_i;
            default: keyed = 1'b1;
        endcase
        if (pix_en_i) begin
            s1_ovl_d = {expand(ovl_r_i), expand(ovl_g_i), expand(ovl_b_i)};
            if (apple_sw_q && key_mode_q != 2'd3) begin
                s1_base_d = {apple_r_i, apple_g_i, apple_b_i};
            end else begin
                s1_base_d = '0;
            end
            s1_alpha_d = (ovl_sw_q && keyed) ? alpha_cur : 5'd0;
        end
    end

    // Stage 2: blend
    logic [2:0][VID_W-1:0] mix_q, mix_d;
    logic                  mix_valid_q, mix_valid_d;

    always_comb begin
        mix_d       = mix_q;
        mix_valid_d = s1_valid_q;
        if (s1_valid_q) begin
            for (int c = 0; c < 3; c++) begin
                mix_d[c] = blend(s1_ovl_q[c], s1_base_q[c], s1_alpha_q);
            end
        end
    end

    always_ff @(posedge clk_logic_i) begin
        if (reset_i) begin
            apple_sw_q  <= 1'b1;
            ovl_sw_q    <= FORCE_OVERLAY;
            key_mode_q  <= 2'd0;
            s1_base_q   <= '0;
            s1_ovl_q    <= '0;
            s1_alpha_q  <= 5'd0;
            s1_valid_q  <= 1'b0;
            mix_q       <= '0;
            mix_valid_q <= 1'b0;
        end else begin
            apple_sw_q  <= apple_sw_d;
            ovl_sw_q    <= ovl_sw_d;
            key_mode_q  <= key_mode_d;
            s1_base_q   <= s1_base_d;
            s1_ovl_q    <= s1_ovl_d;
            s1_alpha_q  <= s1_alpha_d;
            s1_valid_q  <= s1_valid_d;
            mix_q       <= mix_d;
            mix_valid_q <= mix_valid_d;
        end
    end

    assign mix_r_o     = mix_q[2];
    assign mix_g_o     = mix_q[1];
    assign mix_b_o     = mix_q[0];
    assign mix_valid_o = mix_valid_q;
endmodule

// File: tb/tb_ssp_overlay_mixer.sv
// tb/tb_ssp_overlay_mixer.sv - scoreboard bench for ssp_overlay_mixer
module tb_ssp_overlay_mixer;
    logic       clk = 1'b0;
    logic       reset_i = 1'b1;
    logic       wr_stb_i = 1'b0, rd_stb_i = 1'b0;
    logic [3:0] addr_i = 4'h0;
    logic [7:0] data_i = 8'h00;
    logic [7:0] data_o;
    logic       rd_en_o;
    logic       frame_start_i = 1'b0, pix_en_i = 1'b0;
    logic [7:0] apple_r_i = 8'h00, apple_g_i = 8'h00, apple_b_i = 8'h00;
    logic [3:0] ovl_r_i = 4'h0, ovl_g_i = 4'h0, ovl_b_i = 4'h0;
    logic       ovl_transparent_i = 1'b0;
    logic [7:0] mix_r_o, mix_g_o, mix_b_o;
    logic       mix_valid_o, overlay_on_o;

    int checks = 0;
    int errors = 0;
    logic [23:0] exp_q[$];

    ssp_overlay_mixer #(.OVL_W(4), .VID_W(8), .FORCE_OVERLAY(1'b0)) dut (
        .clk_logic_i(clk), .reset_i(reset_i),
        .wr_stb_i(wr_stb_i), .rd_stb_i(rd_stb_i), .addr_i(addr_i),
        .data_i(data_i), .data_o(data_o), .rd_en_o(rd_en_o),
        .frame_start_i(frame_start_i), .pix_en_i(pix_en_i),
        .apple_r_i(apple_r_i), .apple_g_i(apple_g_i), .apple_b_i(apple_b_i),
        .ovl_r_i(ovl_r_i), .ovl_g_i(ovl_g_i), .ovl_b_i(ovl_b_i),
        .ovl_transparent_i(ovl_transparent_i),
        .mix_r_o(mix_r_o), .mix_g_o(mix_g_o), .mix_b_o(mix_b_o),
        .mix_valid_o(mix_valid_o), .overlay_on_o(overlay_on_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: pops one expected pixel per valid output
    always @(negedge clk) begin
        if (!reset_i && mix_valid_o) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_pixel", {mix_r_o, mix_g_o, mix_b_o}, 32'hFFFF_FFFF);
            end else begin
                chk("pixel", {mix_r_o, mix_g_o, mix_b_o}, exp_q.pop_front());
            end
        end
    end

    task automatic wr(input logic [3:0] a, input logic [7:0] d);
        @(posedge clk); #1;
        wr_stb_i = 1'b1; addr_i = a; data_i = d;
        @(posedge clk); #1;
        wr_stb_i = 1'b0;
    endtask

    task automatic rd(input logic [3:0] a, output logic [7:0] d, output logic en);
        rd_stb_i = 1'b1; addr_i = a;
        #1;
        d = data_o; en = rd_en_o;
        rd_stb_i = 1'b0;
    endtask

    task automatic rd_chk(input string name, input logic [3:0] a, input logic [7:0] exp);
        logic [7:0] d;
        logic       en;
        rd(a, d, en);
        chk(name, {en, d}, {1'b1, exp});
    endtask

    task automatic fading_chk(input string name, input logic exp);
        logic [7:0] d;
        logic       en;
        rd(4'hB, d, en);
        chk(name, d[7], exp);
    endtask

    task automatic frame();
        @(posedge clk); #1;
        frame_start_i = 1'b1;
        @(posedge clk); #1;
        frame_start_i = 1'b0;
    endtask

    task automatic pix(input logic [23:0] apple, input logic [11:0] ovl,
                       input logic tr, input logic [23:0] exp);
        @(posedge clk); #1;
        {apple_r_i, apple_g_i, apple_b_i} = apple;
        {ovl_r_i, ovl_g_i, ovl_b_i}       = ovl;
        ovl_transparent_i = tr;
        pix_en_i = 1'b1;
        exp_q.push_back(exp);
        @(posedge clk); #1;
        pix_en_i = 1'b0;
    endtask

    initial begin
        logic [7:0] d;
        logic       en;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_mix", {mix_valid_o, mix_r_o, mix_g_o, mix_b_o}, 32'h0);
        chk("reset_overlay_on", overlay_on_o, 1'b0);
        reset_i = 1'b0;
        rd_chk("reset_reg_b", 4'hB, 8'h20);
        rd_chk("reset_reg_8", 4'h8, 8'h00);
        rd(4'h3, d, en);
        chk("read_unmapped", {en, d}, 9'h000);

        // Overlay switch off: Apple passes even with a bright overlay
        pix(24'h4080C0, 12'hFFF, 1'b0, 24'h4080C0);

        wr(4'h6, 8'h00);
        chk("overlay_on_set", overlay_on_o, 1'b1);
        pix(24'h4080C0, 12'h000, 1'b0, 24'h4080C0);
        pix(24'h4080C0, 12'hF00, 1'b0, 24'hFF0000);
        pix(24'h102030, 12'h080, 1'b1, 24'h008800);

        wr(4'h8, 8'h01);
        rd_chk("key_mode_1", 4'h8, 8'h01);
        pix(24'h4080C0, 12'h000, 1'b0, 24'h000000);
        pix(24'h4080C0, 12'hFFF, 1'b1, 24'h4080C0);

        wr(4'h8, 8'h02);
        pix(24'h4080C0, 12'h123, 1'b1, 24'h112233);

        wr(4'h8, 8'h03);
        rd_chk("reg_b_key3", 4'hB, 8'h78);
        pix(24'h4080C0, 12'h000, 1'b1, 24'h000000);
        pix(24'h4080C0, 12'h080, 1'b1, 24'h008800);

        wr(4'h8, 8'h00);
        wr(4'h3, 8'h00);
        pix(24'h4080C0, 12'h000, 1'b0, 24'h000000);
        wr(4'h4, 8'h00);
        wr(4'h5, 8'h00);
        chk("overlay_on_clear", overlay_on_o, 1'b0);
        pix(24'h4080C0, 12'hF00, 1'b0, 24'h4080C0);
        wr(4'h6, 8'h00);

`ifdef SSP_OVERLAY_FADE_EN
        // Clamp and single-jump fade to alpha 8
        wr(4'h9, 8'h1F);
        rd_chk("alpha_clamp", 4'h9, 8'h10);
        wr(4'h9, 8'h08);
        frame();
        fading_chk("jump_fading", 1'b1);
        frame();
        rd_chk("jump_alpha", 4'h9, 8'h08);
        fading_chk("jump_done", 1'b0);
        pix(24'h000000, 12'hFFF, 1'b0, 24'h7F7F7F);
        wr(4'h9, 8'h10);
        frame();
        frame();
        rd_chk("alpha_back", 4'h9, 8'h10);

        // Slow fade 16 -> 0, one step every 3 frames
        wr(4'hA, 8'h02);
        rd_chk("fade_rate", 4'hA, 8'h02);
        wr(4'h9, 8'h00);
        frame();
        for (int k = 1; k <= 48; k++) begin
            frame();
            rd_chk($sformatf("fade_down_%0d", k), 4'h9, 8'(16 - k / 3));
            fading_chk($sformatf("fading_down_%0d", k), k < 48);
        end

        // Fade up, then reverse at alpha 10
        wr(4'h9, 8'h10);
        frame();
        for (int k = 1; k <= 30; k++) begin
            frame();
            rd_chk($sformatf("fade_up_%0d", k), 4'h9, 8'(k / 3));
        end
        wr(4'h9, 8'h00);
        for (int j = 1; j <= 6; j++) begin
            frame();
            rd_chk($sformatf("fade_rev_%0d", j), 4'h9, 8'(10 - j / 3));
        end
        fading_chk("fading_mid", 1'b1);

        // Reset mid-fade
        @(posedge clk); #1;
        reset_i = 1'b1;
        @(posedge clk); #1;
        rd_chk("reset_alpha", 4'h9, 8'h10);
        rd_chk("reset_reg_b2", 4'hB, 8'h20);
        rd_chk("reset_rate", 4'hA, 8'h00);
        reset_i = 1'b0;
`else
        wr(4'h9, 8'h00);
        wr(4'hA, 8'h05);
        rd_chk("alpha_fixed", 4'h9, 8'h10);
        rd_chk("rate_fixed", 4'hA, 8'h00);
        frame();
        fading_chk("no_fading", 1'b0);
        pix(24'h000000, 12'hFFF, 1'b0, 24'hFFFFFF);
`endif

        for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(posedge clk);
        @(negedge clk);
        chk("scoreboard_drained", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
